// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters with a valid/ready
// request side and a per-requester response handshake. Optional ALU_ARB_ROUND_ROBIN_EN.
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [2*OPCODE_LENGTH-1:0] req_op,
  input  logic [2*DATA_WIDTH-1:0]    req_a,
  input  logic [2*DATA_WIDTH-1:0]    req_b,
  output logic [1:0]                 resp_valid,
  input  logic [1:0]                 resp_ready,
  output logic [DATA_WIDTH-1:0]      resp_data,
  output logic [DATA_WIDTH-1:0]      alu_srca,
  output logic [DATA_WIDTH-1:0]      alu_srcb,
  output logic [OPCODE_LENGTH-1:0]   alu_op,
  input  logic [DATA_WIDTH-1:0]      alu_result,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e                   state_q, state_d;
  logic                     grant_q, grant_d;
  logic                     grant_sel;
  logic                     accept;
  logic [OPCODE_LENGTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0]    a_q, a_d;
  logic [DATA_WIDTH-1:0]    b_q, b_d;
  logic [DATA_WIDTH-1:0]    resp_data_q, resp_data_d;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    if (&req_valid) grant_sel = ~last_grant_q;
    else            grant_sel = ~req_valid[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= grant_sel;
  end
`else
  // Fixed priority: requester 0 wins whenever it is valid.
  assign grant_sel = ~req_valid[0];
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    resp_data_d = resp_data_q;
    req_ready   = 2'b00;
    accept      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          accept               = 1'b1;
          req_ready[grant_sel] = 1'b1;
          grant_d              = grant_sel;
          op_d    = grant_sel ? req_op[2*OPCODE_LENGTH-1:OPCODE_LENGTH] : req_op[OPCODE_LENGTH-1:0];
          a_d     = grant_sel ? req_a[2*DATA_WIDTH-1:DATA_WIDTH]       : req_a[DATA_WIDTH-1:0];
          b_d     = grant_sel ? req_b[2*DATA_WIDTH-1:DATA_WIDTH]       : req_b[DATA_WIDTH-1:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        resp_data_d = alu_result;
        state_d     = RESP;
      end
      RESP: begin
        if (resp_ready[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign alu_srca   = a_q;
  assign alu_srcb   = b_q;
  assign alu_op     = op_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a transaction-level model predicts grants
// and results; a separate monitor checks every response as the DUT presents it.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int OW = 4;

  logic            clk;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*OW-1:0] req_op;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic [1:0]      resp_valid;
  logic [1:0]      resp_ready;
  logic [DW-1:0]   resp_data;
  logic [DW-1:0]   alu_srca;
  logic [DW-1:0]   alu_srcb;
  logic [OW-1:0]   alu_op;
  logic [DW-1:0]   alu_result;
  logic            busy;

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .busy       (busy)
  );

  // Stand-in for the shared ALU: AND, OR, ADD, SUB, SLT; anything else yields 0.
  function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_srca, alu_srcb);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int            acc;
  } exp_t;

  exp_t sb_q[$];
  int   accept_cnt    = 0;
  int   resp_done_cnt = 0;
  logic m_last        = 1'b1;

  // Request-side model: one operation in flight at most, grant by the arbitration rule.
  always @(negedge clk) begin
    logic g;
    exp_t e;
    if (reset) begin
      accept_cnt = 0;
      m_last     = 1'b1;
    end else begin
      check("busy", 64'(busy), 64'(accept_cnt != resp_done_cnt));
      if (accept_cnt == resp_done_cnt && req_valid != 2'b00) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
        g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
`else
        g = (req_valid == 2'b11) ? 1'b0 : req_valid[1];
`endif
        check("req_ready", 64'(req_ready), 64'(2'b01 << g));
        e.port = g;
        e.data = g ? alu_fn(req_op[2*OW-1:OW], req_a[2*DW-1:DW], req_b[2*DW-1:DW])
                   : alu_fn(req_op[OW-1:0],    req_a[DW-1:0],    req_b[DW-1:0]);
        e.acc  = cyc;
        sb_q.push_back(e);
        accept_cnt++;
        m_last = g;
      end else begin
        check("req_ready_idle", 64'(req_ready), 64'(0));
      end
    end
  end

  // Response monitor: exact two-cycle latency, correct port, stable data until taken.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      resp_done_cnt <= 0;
    end else if (sb_q.size() == 0) begin
      check("resp_spurious", 64'(resp_valid), 64'(0));
    end else if (cyc >= sb_q[0].acc + 2) begin
      check("resp_valid", 64'(resp_valid), 64'(2'b01 << sb_q[0].port));
      check("resp_data", 64'(resp_data), 64'(sb_q[0].data));
      if (resp_valid == (2'b01 << sb_q[0].port) && resp_ready[sb_q[0].port]) begin
        void'(sb_q.pop_front());
        resp_done_cnt <= resp_done_cnt + 1;
      end
    end else begin
      check("resp_early", 64'(resp_valid), 64'(0));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v,
                         input logic [OW-1:0] op0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input logic [OW-1:0] op1, input logic [DW-1:0] a1, input logic [DW-1:0] b1);
    req_valid = v;
    req_op    = {op1, op0};
    req_a     = {a1, a0};
    req_b     = {b1, b0};
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < limit) begin
      step(1);
      n++;
    end
    check("drain_timeout", 64'(n >= limit), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  64'(req_ready),  64'(0));
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    check({tag, "_resp_data"},  64'(resp_data),  64'(0));
    check({tag, "_alu_srca"},   64'(alu_srca),   64'(0));
    check({tag, "_alu_srcb"},   64'(alu_srcb),   64'(0));
    check({tag, "_alu_op"},     64'(alu_op),     64'(0));
    check({tag, "_busy"},       64'(busy),       64'(0));
  endtask

  initial begin
    logic [OW-1:0] ops [6];
    logic [DW-1:0] hold;
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
    ops[3] = 4'b0110; ops[4] = 4'b0111; ops[5] = 4'b1111;

    reset      = 1'b1;
    resp_ready = 2'b00;
    set_req(2'b00, '0, '0, '0, '0, '0, '0);
    #3;
    check_all_zero("reset");
    step(3);
    reset = 1'b0;
    check_all_zero("post_reset");

    // Single ADD on port 0, then SUB on port 1 wrapping negative.
    resp_ready = 2'b11;
    set_req(2'b01, 4'b0010, 32'd5, 32'd7, '0, '0, '0);
    step(1);
    req_valid = 2'b00;
    wait_drain(20);
    set_req(2'b10, '0, '0, '0, 4'b0110, 32'd3, 32'd5);
    step(1);
    req_valid = 2'b00;
    wait_drain(20);

    // Both requesters held valid: arbitration order is checked by the model.
    set_req(2'b11, 4'b0010, 32'd1, 32'd1, 4'b0001, 32'd4, 32'd8);
    step(12);
    req_valid = 2'b00;
    wait_drain(20);

    // Backpressure: response held for several cycles while new requests are ignored.
    resp_ready = 2'b00;
    set_req(2'b01, 4'b0010, 32'd9, 32'd10, '0, '0, '0);
    step(1);
    set_req(2'b11, 4'b0110, 32'd50, 32'd1, 4'b0001, 32'd2, 32'd1);
    step(2);
    hold = resp_data;
    for (int i = 0; i < 5; i++) begin
      check("bp_busy", 64'(busy), 64'(1));
      check("bp_data_stable", 64'(resp_data), 64'(hold));
      step(1);
    end
    resp_ready = 2'b10;
    step(2);
    req_valid  = 2'b00;
    resp_ready = 2'b01;
    wait_drain(20);

    // Reset while the operation sits in ISSUE.
    resp_ready = 2'b11;
    set_req(2'b01, 4'b0110, 32'd100, 32'd1, '0, '0, '0);
    step(1);
    req_valid = 2'b00;
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("midop_reset");
    step(2);
    reset = 1'b0;
    step(5);
    set_req(2'b10, '0, '0, '0, 4'b0010, 32'd20, 32'd22);
    step(1);
    req_valid = 2'b00;
    wait_drain(20);

    // Randomized traffic with random backpressure and dropped requests.
    for (int i = 0; i < 400; i++) begin
      set_req(2'($urandom),
              ops[$urandom_range(0, 5)], $urandom, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15)),
              ops[$urandom_range(0, 5)], $urandom, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15)));
      resp_ready = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
      step(1);
    end
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    wait_drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
